// File: rtl/latdff_cfg_loader.sv
// Configuration writer for a bank of LATDFF cells: streams one 4-bit word per
// cell into a shadow bank, commits all cells at once, then pulses GSR.
module latdff_cfg_loader #(
    parameter int N_FF       = 8,
    parameter int GSR_CYCLES = 4,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_data,
    output logic [N_FF-1:0]  SYNCASYNC_01,
    output logic [N_FF-1:0]  FFLAT_01,
    output logic [N_FF-1:0]  INIT01,
    output logic [N_FF-1:0]  SRHILO,
    output logic             GSR,
    output logic [CNT_W-1:0] word_cnt,
    output logic             cfg_done
);

    typedef enum logic [1:0] {IDLE, LOAD, PULSE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        pulse_q, pulse_d;
    logic              gsr_q, gsr_d;
    logic              done_q, done_d;
    logic [N_FF-1:0]   sync_q, sync_d, fflat_q, fflat_d, init_q, init_d, sr_q, sr_d;
    logic [N_FF-1:0]   shSync_q, shSync_d, shFflat_q, shFflat_d;
    logic [N_FF-1:0]   shInit_q, shInit_d, shSr_q, shSr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_q   <= '0;
            gsr_q     <= 1'b0;
            done_q    <= 1'b0;
            sync_q    <= '0;
            fflat_q   <= '0;
            init_q    <= '0;
            sr_q      <= '0;
            shSync_q  <= '0;
            shFflat_q <= '0;
            shInit_q  <= '0;
            shSr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            gsr_q     <= gsr_d;
            done_q    <= done_d;
            sync_q    <= sync_d;
            fflat_q   <= fflat_d;
            init_q    <= init_d;
            sr_q      <= sr_d;
            shSync_q  <= shSync_d;
            shFflat_q <= shFflat_d;
            shInit_q  <= shInit_d;
            shSr_q    <= shSr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = pulse_q;
        gsr_d     = gsr_q;
        done_d    = done_q;
        sync_d    = sync_q;
        fflat_d   = fflat_q;
        init_d    = init_q;
        sr_d      = sr_q;
        shSync_d  = shSync_q;
        shFflat_d = shFflat_q;
        shInit_d  = shInit_q;
        shSr_d    = shSr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    shSync_d  = '0;
                    shFflat_d = '0;
                    shInit_d  = '0;
                    shSr_d    = '0;
                end else if (cfg_valid) begin
                    for (int i = 0; i < N_FF; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shSync_d[i]  = cfg_data[0];
                            shFflat_d[i] = cfg_data[1];
                            shInit_d[i]  = cfg_data[2];
                            shSr_d[i]    = cfg_data[3];
                        end
                    end
                    // Last word: the shadow already includes it, so the whole bank commits together.
                    if (cnt_q == CNT_W'(N_FF - 1)) begin
                        sync_d  = shSync_d;
                        fflat_d = shFflat_d;
                        init_d  = shInit_d;
                        sr_d    = shSr_d;
                        gsr_d   = 1'b1;
                        pulse_d = 8'd1;
                        state_d = PULSE;
                        cnt_d   = CNT_W'(N_FF);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PULSE: begin
                if (pulse_q == 8'(GSR_CYCLES)) begin
                    gsr_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    pulse_d = pulse_q + 8'd1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready    = (state_q == LOAD);
    assign SYNCASYNC_01 = sync_q;
    assign FFLAT_01     = fflat_q;
    assign INIT01       = init_q;
    assign SRHILO       = sr_q;
    assign GSR          = gsr_q;
    assign word_cnt     = cnt_q;
    assign cfg_done     = done_q;

endmodule
